z80_bus_tracer: RTL
===================

// Module: z80_bus_tracer
// PURPOSE
//  Passive monitor on the tv80s external bus, beside the bench memory/IO model.
//  Classifies every completed bus cycle (opcode fetch, mem rd/wr, IO rd/wr, INTA).
//  Logs each cycle as {kind, addr, data, timestamp} into a first-word-fall-through FIFO.
//  The bench drains the FIFO with a valid/ready pop and checks exact bus sequences,
//  not just final register state.
// PARAMETERS
//  DEPTH      16   FIFO entries; power of 2, >= 2
//  TS_W       16   timestamp counter width (clk cycles)
// PORTS
//  clk          in   1      CPU clock; all state on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  enable       in   1      1 = capture; 0 = ignore bus (an in-flight cycle still completes)
//  clear        in   1      sync flush: empties FIFO, zeroes ovf_cnt/ovf; timestamp keeps running
//  m1_n,mreq_n,iorq_n,rd_n,wr_n,rfsh_n  in 1 each   CPU bus strobes, active-low
//  A            in   16     CPU address
//  di           in   8      data driven to CPU (read data)
//  dout         in   8      data driven by CPU (write data)
//  out_valid    out  1      head entry present
//  out_ready    in   1      pop head when out_valid & out_ready
//  out_kind     out  3      head kind (z80_trace_pkg::kind_e)
//  out_addr     out  16     head address
//  out_data     out  8      head data byte
//  out_ts       out  TS_W   head timestamp (cycle in which the bus cycle began)
//  count        out  $clog2(DEPTH)+1  entries held
//  ovf          out  1      sticky: at least one record dropped
//  ovf_cnt      out  8      dropped records, saturates at 8'hFF
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, out_* = 0, count=0, ovf=0, ovf_cnt=0, ts=0, FSM=IDLE.
//  act = rfsh_n & ((~mreq_n|~iorq_n) & (~rd_n|~wr_n) | (~m1_n & ~iorq_n)).
//  Kind priority: INTA(6) if m1&iorq; FETCH(1) if m1&mreq&rd; MEM_RD(2); MEM_WR(3);
//   IO_RD(4); IO_WR(5). Kind 0 is never logged. Refresh cycles (rfsh_n=0) are never logged.
//  FSM, evaluated at posedge:
//   IDLE  : act & enable -> CAP; latch ts, kind, A.  act & ~enable -> SKIP.
//   CAP   : each cycle act=1, relatch A and data (di when reading/INTA, dout when writing),
//           OR-in write kind if wr_n goes low. act=0 -> push record at this edge -> IDLE.
//   SKIP  : act=0 -> IDLE; nothing recorded.
//  Latency: record visible on out_* the cycle after the edge where act is first seen low.
//  Back-to-back: act low for one sample is sufficient; a new cycle can enter CAP at the
//   edge after the push.
//  FIFO full & push & ~pop: record dropped, ovf<=1, ovf_cnt+1 (saturating).
//  Full & push & pop at the same edge: both happen and count is unchanged.
//  Empty & pop: ignored. out_* hold their last value while out_valid=0.
//  clear has priority over push and pop at the same edge; an in-flight CAP is not aborted.
//  ts: free-running TS_W-bit counter, wraps to 0, gated by neither enable nor clear.
//  reset_n low mid-cycle: all state returns to reset values immediately; the partial
//   cycle is lost.
// STRUCTURE
//  z80_trace_pkg: kind_e (IDLE=0,FETCH,MEM_RD,MEM_WR,IO_RD,IO_WR,INTA),
//   trace_rec_t struct {kind_e kind; logic[15:0] addr; logic[7:0] data; logic[TS_W-1:0] ts}.
//  Sub-module trace_fifo (DEPTH, payload type trace_rec_t): FWFT, wrap-around pointers
//   with an extra MSB for full/empty. Tracer FSM + classifier stay in the top module.
// TESTING
//  1 tv80s runs DD CB 5E 6C at 0000, IX=3E21, mem[3E7F]=2A -> FETCH 0000/DD, FETCH 0001/CB,
//    MEM_RD 0002/5E, MEM_RD 0003/6C, MEM_RD 3E7F/2A, in that order, strictly rising ts.
//  2 Driven bus: mem write A=1234 dout=A5, then IO write A=00FE dout=3C
//    -> MEM_WR 1234/A5, IO_WR 00FE/3C; a refresh in between is not logged.
//  3 DEPTH+3 cycles with out_ready=0 -> count=DEPTH, ovf=1, ovf_cnt=3; the first DEPTH
//    records drain in order.
//  4 Full FIFO, cycle end coincides with out_ready=1 -> count stays DEPTH, ovf stays 0.
//  5 enable falls mid-CAP -> that record is still logged; the next cycle (enable=0) is
//    not logged. clear with count=5 -> count=0, out_valid=0 the next cycle.
//  6 reset_n pulsed low during CAP -> all outputs at reset values, no partial record;
//    ts restarts at 0.

Source files
------------

// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: record layout, cycle kinds, FSM states
// and the strobe classifier used by the tracer front end.
package z80_trace_pkg;

    localparam int REC_TS_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        IO_RD  = 3'd4,
        IO_WR  = 3'd5,
        INTA   = 3'd6
    } kind_e;

    typedef struct packed {
        kind_e                kind;
        logic [15:0]          addr;
        logic [7:0]           data;
        logic [REC_TS_W-1:0]  ts;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_SKIP = 2'd2
    } trc_state_e;

    // Highest-priority match wins; INTA must beat the IO kinds since iorq is low in both.
    function automatic kind_e classify(input logic m1_n, input logic mreq_n,
                                       input logic iorq_n, input logic rd_n,
                                       input logic wr_n);
        kind_e k;
        k = IDLE;
        if (!m1_n && !iorq_n)                k = INTA;
        else if (!m1_n && !mreq_n && !rd_n)  k = FETCH;
        else if (!mreq_n && !rd_n)           k = MEM_RD;
        else if (!mreq_n && !wr_n)           k = MEM_WR;
        else if (!iorq_n && !rd_n)           k = IO_RD;
        else if (!iorq_n && !wr_n)           k = IO_WR;
        return k;
    endfunction

endpackage

// File: rtl/z80_bus_tracer_fifo.sv
// First-word-fall-through record FIFO with wrap-around pointers (extra MSB
// distinguishes full from empty); the head holds its last value once drained.
module trace_fifo #(
    parameter int  DEPTH     = 16,
    parameter type payload_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  payload_t                 push_data,
    input  logic                     pop,
    output payload_t                 head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    payload_t    mem [DEPTH];
    payload_t    hold_q;
    logic        empty, full, do_pop, do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty && !clear;
    // A pop at the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && !clear && (!full || do_pop);
    assign drop    = push && !clear && full && !do_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Remember the departing head so out_* keep their last value when empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else if (do_pop || (clear && !empty)) begin
            hold_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign head       = empty ? hold_q : mem[rd_ptr[AW-1:0]];
    assign head_valid = !empty;
    assign count      = wr_ptr - rd_ptr;

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive tv80s bus monitor: classifies each completed bus cycle and logs
// {kind, addr, data, start timestamp} into a FWFT FIFO drained by valid/ready.
module z80_bus_tracer
    import z80_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = REC_TS_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     m1_n,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     rfsh_n,
    input  logic [15:0]              A,
    input  logic [7:0]               di,
    input  logic [7:0]               dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output kind_e                    out_kind,
    output logic [15:0]              out_addr,
    output logic [7:0]               out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [7:0]               ovf_cnt
);

    // Handshake: a record leaves the FIFO at a rising edge where out_valid and
    // out_ready are both high; out_* are stable while out_valid is low.

    logic        act;
    kind_e       bus_kind;
    logic [7:0]  bus_data;
    logic [TS_W-1:0] ts_q;
    trc_state_e  state, state_nxt;
    logic        start_cap, push;
    trace_rec_t  cur, head;
    logic        drop;

    assign act = rfsh_n & (((~mreq_n | ~iorq_n) & (~rd_n | ~wr_n)) | (~m1_n & ~iorq_n));
    assign bus_kind = classify(m1_n, mreq_n, iorq_n, rd_n, wr_n);
    assign bus_data = !wr_n ? dout : di;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_cap = 1'b0;
        push      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (act && enable) begin
                    state_nxt = ST_CAP;
                    start_cap = 1'b1;
                end else if (act) begin
                    state_nxt = ST_SKIP;
                end
            end
            ST_CAP: begin
                if (!act) begin
                    state_nxt = ST_IDLE;
                    push      = 1'b1;
                end
            end
            ST_SKIP: begin
                if (!act) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address/data follow the bus while active so the record holds end-of-cycle values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= '0;
        end else if (start_cap) begin
            cur.kind <= bus_kind;
            cur.addr <= A;
            cur.data <= bus_data;
            cur.ts   <= REC_TS_W'(ts_q);
        end else if (state == ST_CAP && act) begin
            cur.addr <= A;
            cur.data <= bus_data;
            if (!wr_n && (cur.kind == MEM_RD || cur.kind == IO_RD))
                cur.kind <= kind_e'({cur.kind[2:1], 1'b1});
        end
    end

    trace_fifo #(
        .DEPTH     (DEPTH),
        .payload_t (trace_rec_t)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (push),
        .push_data  (cur),
        .pop        (out_ready),
        .head       (head),
        .head_valid (out_valid),
        .count      (count),
        .drop       (drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= 8'h00;
        end else if (clear) begin
            ovf     <= 1'b0;
            ovf_cnt <= 8'h00;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign out_kind = head.kind;
    assign out_addr = head.addr;
    assign out_data = head.data;
    assign out_ts   = TS_W'(head.ts);

endmodule
